// File: rtl/lsu_ctrl_pkg.sv
// lsu_ctrl_pkg: shared FSM state and access-size encodings for the load/store unit.
package lsu_ctrl_pkg;
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_WRITE  = 3'd2;
  localparam logic [2:0] S_RMW_RD = 3'd3;
  localparam logic [2:0] S_RMW_WR = 3'd4;
  localparam logic [2:0] S_RESP   = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;
  localparam logic [1:0] SIZE_B   = 2'b00;
  localparam logic [1:0] SIZE_H   = 2'b01;
  localparam logic [1:0] SIZE_W   = 2'b10;
  localparam logic [1:0] SIZE_BAD = 2'b11;
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
    return (size == SIZE_H && a[0]) || (size == SIZE_W && a != 2'b00);
  endfunction
endpackage

// File: rtl/lsu_lane_fmt.sv
// lsu_lane_fmt: extracts/extends a load lane and merges a store lane into a memory word.
module lsu_lane_fmt
  import lsu_ctrl_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] wdata,
  output logic [31:0] ld_val,
  output logic [31:0] st_word
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = word[{addr, 3'b000} +: 8];
    h = addr[1] ? word[31:16] : word[15:0];
    ld_val = size == SIZE_B ? {{24{b[7] & ~uns}}, b} :
             size == SIZE_H ? {{16{h[15] & ~uns}}, h} : word;
    st_word = word;
    if (size == SIZE_B) st_word[{addr, 3'b000} +: 8] = wdata[7:0];
    else if (size == SIZE_H) st_word[{addr[1], 4'b0000} +: 16] = wdata[15:0];
  end
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding load/store unit with sub-word read-modify-write and access checks.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_uns,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_din,
  output logic              dm_we,
  input  logic [31:0]       dm_dout
);
  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              we_q, we_d, uns_q, uns_d;
  logic [31:0]       wdata_q, wdata_d, rdata_q, rdata_d, merge_q, merge_d;
  logic [31:0]       ld_val, st_word;
  logic              err, acc;

  lsu_lane_fmt u_fmt (
    .word   (dm_dout),
    .addr   (addr_q[1:0]),
    .size   (size_q),
    .uns    (uns_q),
    .wdata  (wdata_q),
    .ld_val (ld_val),
    .st_word(st_word)
  );

  assign req_ready  = rst_n && state_q == S_IDLE;
  assign resp_valid = state_q == S_RESP || state_q == S_ERR;
  assign resp_err   = state_q == S_ERR;
  assign resp_rdata = rdata_q;
  assign dm_addr    = {addr_q[ADDR_W-1:2], 2'b00};
  assign dm_din     = state_q == S_WRITE ? wdata_q : state_q == S_RMW_WR ? merge_q : '0;
  // Gated by rst_n so a reset landing on a write cycle never commits a partial store.
  assign dm_we      = rst_n && (state_q == S_WRITE || state_q == S_RMW_WR);

  always_comb begin
    err = req_size == SIZE_BAD || |req_addr[31:ADDR_W] || is_misaligned(req_size, req_addr[1:0]);
    acc = req_valid && req_ready;
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    we_d    = we_q;
    uns_d   = uns_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    merge_d = merge_q;
    case (state_q)
      S_IDLE: if (acc) begin
        addr_d  = req_addr[ADDR_W-1:0];
        size_d  = req_size;
        we_d    = req_we;
        uns_d   = req_uns;
        wdata_d = req_wdata;
        state_d = err ? S_ERR : !req_we ? S_LOAD : req_size == SIZE_W ? S_WRITE : S_RMW_RD;
        if (err) rdata_d = '0;
      end
      S_LOAD: begin
        rdata_d = ld_val;
        state_d = S_RESP;
      end
      S_RMW_RD: begin
        merge_d = st_word;
        state_d = S_RMW_WR;
      end
      S_WRITE, S_RMW_WR: begin
        rdata_d = '0;
        state_d = S_RESP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      merge_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      merge_q <= merge_d;
    end
  end
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed checks of lsu_ctrl against a byte-array data memory.
module tb_lsu_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_uns = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_err, dm_we;
  logic [31:0] resp_rdata, dm_din, dm_dout;
  logic [9:0]  dm_addr;
  logic [7:0]  mem [0:1023];
  int          errors = 0, checks = 0, we_cnt = 0;
  logic [9:0]  last_wa;
  logic [31:0] last_wd;

  lsu_ctrl #(.ADDR_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_uns(req_uns), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata), .dm_addr(dm_addr), .dm_din(dm_din), .dm_we(dm_we),
    .dm_dout(dm_dout)
  );

  always #5 clk = ~clk;

  assign dm_dout = {mem[{dm_addr[9:2], 2'd3}], mem[{dm_addr[9:2], 2'd2}],
                    mem[{dm_addr[9:2], 2'd1}], mem[{dm_addr[9:2], 2'd0}]};

  always @(posedge clk) if (dm_we) begin
    we_cnt++;
    last_wa = dm_addr;
    last_wd = dm_din;
    {mem[{dm_addr[9:2], 2'd3}], mem[{dm_addr[9:2], 2'd2}],
     mem[{dm_addr[9:2], 2'd1}], mem[{dm_addr[9:2], 2'd0}]} = dm_din;
  end

  function automatic logic [31:0] rd32(input int a);
    return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, input logic keep,
                        output int lat, output logic [31:0] rd, output logic er,
                        output logic rdy_busy);
    int n = 0;
    req_we = we; req_size = sz; req_uns = uns; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("accept_timeout", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 if (!keep) req_valid = 1'b0;
    lat = 0;
    rdy_busy = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      if (req_ready && !resp_valid) rdy_busy = 1'b1;
    end while (!resp_valid && lat < 10);
    rd = resp_rdata;
    er = resp_err;
  endtask

  int          lat, wc;
  logic [31:0] rd;
  logic        er, rb;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[16] = 8'hA5; mem[17] = 8'hF0; mem[18] = 8'h77; mem[19] = 8'h88;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_valid", 32'(resp_valid), 0);
    chk("rst_we", 32'(dm_we), 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_din", dm_din, 0);
    chk("rst_addr", 32'(dm_addr), 0);
    rst_n = 1'b1;
    @(negedge clk);

    do_req(0, 2'b00, 0, 32'h011, 0, 0, lat, rd, er, rb);
    chk("lb_data", rd, 32'hFFFFFFF0);
    chk("lb_lat", 32'(lat), 2);
    chk("lb_err", 32'(er), 0);
    @(negedge clk);
    chk("lb_pulse", 32'(resp_valid), 0);
    do_req(0, 2'b00, 1, 32'h011, 0, 0, lat, rd, er, rb);
    chk("lbu_data", rd, 32'h000000F0);
    do_req(0, 2'b01, 0, 32'h012, 0, 0, lat, rd, er, rb);
    chk("lh_data", rd, 32'hFFFF8877);
    do_req(0, 2'b01, 1, 32'h012, 0, 0, lat, rd, er, rb);
    chk("lhu_data", rd, 32'h00008877);
    do_req(0, 2'b10, 1, 32'h010, 0, 0, lat, rd, er, rb);
    chk("lw_data", rd, 32'h8877F0A5);
    chk("lw_lat", 32'(lat), 2);

    wc = we_cnt;
    do_req(1, 2'b00, 0, 32'h012, 32'h1234563C, 0, lat, rd, er, rb);
    chk("sb_lat", 32'(lat), 3);
    chk("sb_wecnt", 32'(we_cnt - wc), 1);
    chk("sb_waddr", 32'(last_wa), 32'h010);
    chk("sb_wdata", last_wd, 32'h883CF0A5);
    chk("sb_rdata", rd, 0);
    do_req(0, 2'b10, 0, 32'h010, 0, 0, lat, rd, er, rb);
    chk("sb_readback", rd, 32'h883CF0A5);
    do_req(0, 2'b01, 0, 32'h010, 0, 0, lat, rd, er, rb);
    chk("lh_lo", rd, 32'hFFFFF0A5);

    wc = we_cnt;
    do_req(1, 2'b01, 0, 32'h011, 32'hFFFF, 0, lat, rd, er, rb);
    chk("sh_mis_err", 32'(er), 1);
    chk("sh_mis_lat", 32'(lat), 1);
    do_req(0, 2'b10, 0, 32'h012, 0, 0, lat, rd, er, rb);
    chk("lw_mis_err", 32'(er), 1);
    chk("lw_mis_rdata", rd, 0);
    do_req(0, 2'b00, 0, 32'h400, 0, 0, lat, rd, er, rb);
    chk("lb_range_err", 32'(er), 1);
    chk("lb_range_lat", 32'(lat), 1);
    do_req(1, 2'b11, 0, 32'h010, 32'h55, 0, lat, rd, er, rb);
    chk("size_bad_err", 32'(er), 1);
    chk("err_no_write", 32'(we_cnt - wc), 0);
    chk("err_mem", rd32(16), 32'h883CF0A5);

    wc = we_cnt;
    req_we = 1; req_size = 2'b10; req_addr = 32'h014; req_wdata = 32'hDEADBEEF; req_valid = 1;
    @(posedge clk);
    #1 req_valid = 0;
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk("rst_mid_we", 32'(dm_we), 0);
    @(negedge clk);
    chk("rst_mid_wecnt", 32'(we_cnt - wc), 0);
    chk("rst_mid_mem", rd32(20), 0);
    chk("rst_mid_valid", 32'(resp_valid), 0);
    chk("rst_mid_err", 32'(resp_err), 0);
    chk("rst_mid_rdata", resp_rdata, 0);
    chk("rst_mid_din", dm_din, 0);
    chk("rst_mid_addr", 32'(dm_addr), 0);
    chk("rst_mid_ready", 32'(req_ready), 0);
    rst_n = 1'b1;
    #1 chk("rst_rel_ready", 32'(req_ready), 1);
    @(negedge clk);

    do_req(1, 2'b10, 0, 32'h018, 32'hCAFEF00D, 1, lat, rd, er, rb);
    chk("b2b_sw_lat", 32'(lat), 2);
    chk("b2b_busy_ready", 32'(rb), 0);
    do_req(0, 2'b10, 0, 32'h018, 0, 0, lat, rd, er, rb);
    chk("b2b_lw_data", rd, 32'hCAFEF00D);
    chk("b2b_busy_ready2", 32'(rb), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
